// File: rtl/gpio_sequencer.sv
// Bus-programmable GPIO pattern sequencer: plays up to eight (pattern, hold)
// steps as single-byte writes to a GPIO register over a simple master port.
module gpio_sequencer #(
  parameter logic [31:0] ADDR      = 32'hffff_ff00,
  parameter logic [31:0] GPIO_ADDR = 32'hffff_fff0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        seq_ready,
  output logic        seq_sel,
  output logic [31:0] seq_rdata,
  output logic        m_valid,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  input  logic        m_ready
);
  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

  state_t      state;
  logic [2:0]  step;
  logic [2:0]  len;
  logic [15:0] cnt;
  logic        loop;
  logic        done;
  logic        stop_pend;
  logic [7:0]  pattern;
  logic [23:0] steps [8];

  logic [31:0] offset;
  logic        wr;
  logic        rd;
  logic        ctrl_wr;
  logic        start;
  logic        stop;
  logic        busy;
  logic [2:0]  widx;
  logic [2:0]  next_step;
  logic [31:0] rd_val;
  logic        unused_wdata;

  assign offset    = mem_addr - ADDR;
  assign seq_sel   = mem_valid && (offset[1:0] == 2'b00) && (offset <= 32'h24);
  assign wr        = seq_sel && (mem_wstrb != 4'b0000);
  assign rd        = seq_sel && (mem_wstrb == 4'b0000);
  assign ctrl_wr   = wr && (offset[5:2] == 4'd0);
  // STOP dominates START when both arrive in one write
  assign start     = ctrl_wr && mem_wdata[0] && !mem_wdata[2];
  assign stop      = ctrl_wr && mem_wdata[2];
  assign widx      = 3'(offset[5:2] - 4'd2);
  assign busy      = (state != IDLE);
  assign next_step = (step == len) ? 3'd0 : step + 3'd1;

  assign seq_ready    = 1'b1;
  assign m_addr       = GPIO_ADDR;
  assign m_wdata      = {24'h0, pattern};
  assign m_wstrb      = {3'b000, m_valid};
  assign unused_wdata = ^mem_wdata[31:24];

  always_comb begin
    rd_val = 32'h0;
    case (offset[5:2])
      4'd0:    rd_val = {25'h0, step, done, 1'b0, loop, busy};
      4'd1:    rd_val = {29'h0, len};
      default: rd_val = {8'h0, steps[widx]};
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      step      <= 3'd0;
      len       <= 3'd0;
      cnt       <= 16'd0;
      loop      <= 1'b0;
      done      <= 1'b0;
      stop_pend <= 1'b0;
      pattern   <= 8'h0;
      m_valid   <= 1'b0;
      seq_rdata <= 32'h0;
      for (int i = 0; i < 8; i++) steps[i] <= 24'h0;
    end else begin
      seq_rdata <= rd ? rd_val : 32'h0;
      if (wr) begin
        case (offset[5:2])
          4'd0:    loop <= mem_wdata[1];
          4'd1:    len  <= mem_wdata[2:0];
          default: steps[widx] <= mem_wdata[23:0];
        endcase
      end
      case (state)
        IDLE: begin
          if (start) begin
            state     <= ISSUE;
            done      <= 1'b0;
            step      <= 3'd0;
            pattern   <= steps[0][7:0];
            m_valid   <= 1'b1;
            stop_pend <= 1'b0;
          end
        end
        ISSUE: begin
          // A STOP here is only remembered; the request must complete first
          if (stop) stop_pend <= 1'b1;
          if (m_ready) begin
            m_valid <= 1'b0;
            if (stop || stop_pend) begin
              state     <= IDLE;
              stop_pend <= 1'b0;
            end else begin
              cnt   <= steps[step][23:8];
              state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (stop) begin
            state <= IDLE;
          end else if (cnt != 16'd0) begin
            cnt <= cnt - 16'd1;
          end else if ((step != len) || loop) begin
            step    <= next_step;
            pattern <= steps[next_step][7:0];
            m_valid <= 1'b1;
            state   <= ISSUE;
          end else begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gpio_sequencer.sv
// Self-checking bench for gpio_sequencer: register table, directed corner
// sequences and randomized programs checked against a transaction-level model.
module tb_gpio_sequencer;
  localparam logic [31:0] BASE = 32'hffff_ff00;
  localparam logic [31:0] GPIO = 32'hffff_fff0;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_addr = 32'h0;
  logic [31:0] mem_wdata = 32'h0;
  logic [3:0]  mem_wstrb = 4'h0;
  logic        m_ready = 1'b0;
  logic        seq_ready;
  logic        seq_sel;
  logic [31:0] seq_rdata;
  logic        m_valid;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;

  int checks = 0;
  int errors = 0;

  logic [7:0]  exp_pat  [8];
  logic [15:0] exp_hold [8];

  typedef struct {
    logic [31:0] off;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_sel;
  } vec_t;
  vec_t vecs [16];

  gpio_sequencer #(.ADDR(BASE), .GPIO_ADDR(GPIO)) dut (
    .clk(clk), .resetn(resetn),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .seq_ready(seq_ready), .seq_sel(seq_sel), .seq_rdata(seq_rdata),
    .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] off, input logic [31:0] data);
    mem_valid = 1'b1; mem_addr = BASE + off; mem_wdata = data; mem_wstrb = 4'hf;
    @(negedge clk);
    mem_valid = 1'b0; mem_wstrb = 4'h0;
  endtask

  task automatic bus_read(input logic [31:0] off, output logic [31:0] data);
    mem_valid = 1'b1; mem_addr = BASE + off; mem_wstrb = 4'h0;
    @(negedge clk);
    data = seq_rdata;
    mem_valid = 1'b0;
  endtask

  task automatic program_seq(input int last);
    for (int i = 0; i <= last; i++) bus_write(32'h8 + 32'(4 * i), {8'h0, exp_hold[i], exp_pat[i]});
    bus_write(32'h4, 32'(last));
  endtask

  // Model: step k is written as exp_pat[k]; after its handshake the port is
  // quiet for hold+1 cycles; after the last step the block reports done.
  task automatic run_seq(input int nsteps, input bit rand_ready, input int stall);
    int idx = 0;
    int cyc = 0;
    int expect_rise = 0;
    int last_hs = 0;
    logic exp_v;
    logic [31:0] rd;
    while (idx < nsteps && cyc < 2000) begin
      exp_v = (cyc >= expect_rise);
      check("seq_m_valid", m_valid, exp_v);
      if (m_valid && exp_v) begin
        check("seq_m_wdata", m_wdata, {24'h0, exp_pat[idx]});
        check("seq_m_addr", m_addr, GPIO);
        check("seq_m_wstrb", m_wstrb, 4'b0001);
      end else begin
        check("seq_idle_wstrb", m_wstrb, 4'b0000);
      end
      if (cyc < stall) m_ready = 1'b0;
      else m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (m_valid && m_ready) begin
        last_hs = cyc;
        expect_rise = cyc + int'(exp_hold[idx]) + 2;
        idx++;
      end
      @(negedge clk);
      cyc++;
    end
    m_ready = 1'b0;
    check("seq_complete", idx, nsteps);
    while (cyc < last_hs + int'(exp_hold[nsteps-1]) + 1) begin
      check("seq_last_hold_quiet", m_valid, 1'b0);
      @(negedge clk);
      cyc++;
    end
    bus_read(32'h0, rd);
    check("seq_last_hold_ctrl", rd, (32'(nsteps - 1) << 4) | 32'h1);
    bus_read(32'h0, rd);
    check("seq_done_ctrl", rd, (32'(nsteps - 1) << 4) | 32'h8);
  endtask

  initial begin
    logic [31:0] rd;
    bit seen7, seen0, got;
    int last;

    vecs[0]  = '{32'h04, 4'hf, 32'h0000_0005, 32'h0,         1'b1};
    vecs[1]  = '{32'h04, 4'h0, 32'h0,         32'h5,         1'b1};
    vecs[2]  = '{32'h04, 4'hf, 32'hffff_fffa, 32'h0,         1'b1};
    vecs[3]  = '{32'h04, 4'h0, 32'h0,         32'h2,         1'b1};
    vecs[4]  = '{32'h14, 4'h1, 32'hdead_beef, 32'h0,         1'b1};
    vecs[5]  = '{32'h14, 4'h0, 32'h0,         32'h00ad_beef, 1'b1};
    vecs[6]  = '{32'h24, 4'hc, 32'h00ff_ff01, 32'h0,         1'b1};
    vecs[7]  = '{32'h24, 4'h0, 32'h0,         32'h00ff_ff01, 1'b1};
    vecs[8]  = '{32'h28, 4'h0, 32'h0,         32'h0,         1'b0};
    vecs[9]  = '{32'h02, 4'h0, 32'h0,         32'h0,         1'b0};
    vecs[10] = '{32'h00, 4'hf, 32'h0000_0002, 32'h0,         1'b1};
    vecs[11] = '{32'h00, 4'h0, 32'h0,         32'h2,         1'b1};
    vecs[12] = '{32'h00, 4'hf, 32'h0000_0005, 32'h0,         1'b1};
    vecs[13] = '{32'h00, 4'h0, 32'h0,         32'h0,         1'b1};
    vecs[14] = '{32'h08, 4'h0, 32'h0,         32'h0,         1'b1};
    vecs[15] = '{32'hffff_fffc, 4'h0, 32'h0,  32'h0,         1'b0};

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_m_wstrb", m_wstrb, 4'h0);
    check("rst_m_wdata", m_wdata, 32'h0);
    check("rst_seq_rdata", seq_rdata, 32'h0);
    check("rst_seq_ready", seq_ready, 1'b1);
    check("rst_m_addr", m_addr, GPIO);
    resetn = 1'b1;
    @(negedge clk);
    bus_read(32'h0, rd);
    check("rst_ctrl", rd, 32'h0);

    // register table
    for (int i = 0; i < 16; i++) begin
      mem_valid = 1'b1; mem_addr = BASE + vecs[i].off;
      mem_wdata = vecs[i].wdata; mem_wstrb = vecs[i].strb;
      #1;
      check($sformatf("tbl_sel_%0d", i), seq_sel, vecs[i].exp_sel);
      @(negedge clk);
      check($sformatf("tbl_rdata_%0d", i), seq_rdata, vecs[i].exp_rd);
      check($sformatf("tbl_idle_%0d", i), m_valid, 1'b0);
    end
    mem_valid = 1'b0; mem_wstrb = 4'h0;

    // single pass
    exp_pat[0] = 8'ha5; exp_hold[0] = 16'd2;
    exp_pat[1] = 8'h3c; exp_hold[1] = 16'd0;
    program_seq(1);
    bus_write(32'h0, 32'h1);
    run_seq(2, 1'b0, 0);

    // backpressure for 4 cycles
    exp_pat[0] = 8'ha5; exp_hold[0] = 16'd2;
    program_seq(0);
    bus_write(32'h0, 32'h1);
    run_seq(1, 1'b0, 4);

    // loop wrap 7 -> 0, then STOP in HOLD
    for (int i = 0; i < 8; i++) begin exp_pat[i] = 8'h10 + 8'(i); exp_hold[i] = 16'd3; end
    program_seq(7);
    m_ready = 1'b1;
    bus_write(32'h0, 32'h3);
    seen7 = 0; seen0 = 0; got = 0;
    for (int c = 0; c < 300 && !got; c++) begin
      if (seen0 && !m_valid) got = 1;
      else begin
        bus_read(32'h0, rd);
        if (!seen7 && rd[6:4] == 3'd7) seen7 = 1;
        else if (seen7 && !seen0 && rd[6:4] != 3'd7) begin
          check("wrap_step", {29'h0, rd[6:4]}, 32'h0);
          seen0 = 1;
        end
      end
    end
    check("wrap_reached", {31'h0, got}, 32'h1);
    bus_write(32'h0, 32'h4);
    bus_read(32'h0, rd);
    check("stop_hold_ctrl", rd, 32'h0);
    check("stop_hold_valid", m_valid, 1'b0);
    m_ready = 1'b0;

    // STOP while ISSUE is stalled
    exp_pat[0] = 8'h5a; exp_hold[0] = 16'd5;
    program_seq(0);
    bus_write(32'h0, 32'h1);
    check("stall_valid_pre", m_valid, 1'b1);
    bus_write(32'h0, 32'h4);
    for (int c = 0; c < 3; c++) begin
      check("stop_stall_valid", m_valid, 1'b1);
      check("stop_stall_wdata", m_wdata, 32'h5a);
      @(negedge clk);
    end
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    check("stop_hs_valid", m_valid, 1'b0);
    bus_read(32'h0, rd);
    check("stop_issue_ctrl", rd, 32'h0);
    check("stop_issue_no_reissue", m_valid, 1'b0);

    // START while busy is ignored
    exp_pat[0] = 8'h01; exp_hold[0] = 16'd0;
    exp_pat[1] = 8'h02; exp_hold[1] = 16'd20;
    program_seq(1);
    m_ready = 1'b1;
    bus_write(32'h0, 32'h1);
    repeat (5) @(negedge clk);
    bus_write(32'h0, 32'h1);
    bus_read(32'h0, rd);
    check("start_busy_ctrl", rd, 32'h11);
    check("start_busy_no_issue", m_valid, 1'b0);
    bus_write(32'h0, 32'h4);
    bus_read(32'h0, rd);
    check("start_busy_stop", rd, 32'h10);
    m_ready = 1'b0;

    // reset in the middle of ISSUE
    exp_pat[0] = 8'hc3; exp_hold[0] = 16'd1;
    program_seq(0);
    bus_write(32'h0, 32'h1);
    check("rst_mid_pre_valid", m_valid, 1'b1);
    #2 resetn = 1'b0;
    #1;
    check("rst_mid_valid", m_valid, 1'b0);
    check("rst_mid_wdata", m_wdata, 32'h0);
    check("rst_mid_wstrb", m_wstrb, 4'h0);
    @(negedge clk);
    resetn = 1'b1;
    m_ready = 1'b1;
    bus_read(32'h0, rd);
    check("rst_mid_ctrl", rd, 32'h0);
    bus_read(32'h8, rd);
    check("rst_mid_step0", rd, 32'h0);
    repeat (3) begin
      check("rst_mid_stay_idle", m_valid, 1'b0);
      @(negedge clk);
    end
    m_ready = 1'b0;

    // randomized programs
    for (int r = 0; r < 4; r++) begin
      last = $urandom_range(0, 7);
      for (int i = 0; i <= last; i++) begin
        exp_pat[i]  = 8'($urandom);
        exp_hold[i] = 16'($urandom_range(0, 4));
      end
      program_seq(last);
      bus_write(32'h0, 32'h1);
      run_seq(last + 1, 1'b1, $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/gpio_sequencer.md
GPIO_SEQUENCER -- requirements
Module: gpio_sequencer

Interface
REQ-001 The block SHALL have parameter ADDR, default 32'hffff_ff00, meaning the word-aligned base address of the sequencer register window.
REQ-002 The block SHALL have parameter GPIO_ADDR, default 32'hffff_fff0, meaning the address of the GPIO write register the block drives.
REQ-003 The block SHALL have one clock and an asynchronous active-low reset: clk  input  1  rising-edge clock.
REQ-004 resetn  input  1  asynchronous active-low reset.
REQ-005 mem_valid  input  1  bus request valid (slave side).
REQ-006 mem_addr  input  32  bus address.
REQ-007 mem_wdata  input  32  bus write data.
REQ-008 mem_wstrb  input  4  byte write strobes; 4'b0000 means read.
REQ-009 seq_ready  output  1  slave ready, constant 1.
REQ-010 seq_sel  output  1  high when mem_valid and mem_addr is in the range ADDR..ADDR+0x24, word-aligned.
REQ-011 seq_rdata  output  32  registered read data.
REQ-012 m_valid  output  1  master write request toward GPIO.
REQ-013 m_addr  output  32  master address, constant GPIO_ADDR.
REQ-014 m_wdata  output  32  master write data, {24'h0, pattern}.
REQ-015 m_wstrb  output  4  master strobes, 4'b0001 while m_valid, else 4'b0000.
REQ-016 m_ready  input  1  master accept; the handshake completes on a rising edge where m_valid and m_ready are both high.

Function
REQ-017 Register map:
- +0x00 CTRL. Write: bit0 START, bit1 LOOP (stored), bit2 STOP.
- CTRL read: bit0 busy, bit1 loop, bit3 done, bits6:4 current step, other bits 0.
- +0x04 LEN: bits2:0 last step index; the sequence has LEN+1 steps.
- +0x08+4*i STEP[i], i=0..7: bits7:0 pattern, bits23:8 hold count.
REQ-018 A register write SHALL occur when mem_valid is high, the address matches, and mem_wstrb is nonzero; write data is taken whole-word, with no per-byte merge.
REQ-019 seq_rdata SHALL present, one cycle after a read request, the selected register value; unused bits read 0; a non-selected or write cycle loads 0.
REQ-020 The FSM SHALL have the states IDLE, ISSUE, and HOLD; busy is high in ISSUE and HOLD.
REQ-021 IDLE:
- On START, the block SHALL go to ISSUE, clear done, and set step to 0.
- On entering ISSUE, the block SHALL latch STEP[step].pattern into m_wdata.
REQ-022 ISSUE:
- m_valid SHALL be high, and m_wdata SHALL be stable until the handshake.
- On the handshake, the block SHALL load a 16-bit counter with STEP[step].hold and go to HOLD.
REQ-023 HOLD:
- If the counter is 0, the block SHALL advance; otherwise it SHALL decrement the counter.
- HOLD therefore lasts hold+1 cycles, with no wrap below 0.
REQ-024 Advance:
- If step is not equal to LEN, then step is set to step+1 and the FSM goes to ISSUE.
- If step equals LEN and loop is set, then step is set to 0 and the FSM goes to ISSUE.
- If step equals LEN and loop is clear, the FSM goes to IDLE and done is set to 1.
REQ-025 STOP in HOLD SHALL return the FSM to IDLE on the next edge; done SHALL stay 0.
REQ-026 STOP in ISSUE SHALL be recorded and take effect on the handshake, going to IDLE instead of HOLD; m_valid SHALL never drop before the handshake.
REQ-027 START while busy SHALL be ignored; START and STOP in the same write SHALL act as STOP only.
REQ-028 Writes to LEN and STEP while busy SHALL be accepted; they take effect at the next ISSUE entry (pattern) or handshake (hold).
REQ-029 LOOP written while busy SHALL be honoured at the next advance.
REQ-030 The step index SHALL be 3 bits; LEN=7 with loop SHALL wrap from 7 to 0.

Reset
REQ-031 While resetn is low, the block SHALL immediately force the following, asynchronously:
- FSM to IDLE; step, counter, LEN, loop, done, and the stop-pending flag to 0.
- All STEP registers to 0.
- m_valid to 0, m_wdata to 0, m_wstrb to 0, and seq_rdata to 0.
REQ-032 Reset asserted mid-ISSUE SHALL drop m_valid without a handshake; after release, the block SHALL stay IDLE until START.

Verification
REQ-033 The bench SHALL cover a single pass: with STEP0=(8'hA5, hold 2), STEP1=(8'h3C, hold 0), LEN=1, and m_ready=1, write CTRL=1. Required response: the writes 0xA5 then 0x3C; HOLD lasts 3 and 1 cycles; afterwards busy=0 and done=1.
REQ-034 The bench SHALL cover backpressure: with m_ready low for 4 cycles in ISSUE, m_valid, m_addr=GPIO_ADDR, m_wdata=0x000000A5, and m_wstrb=1 SHALL be held stable, and the hold count SHALL start only after the handshake.
REQ-035 The bench SHALL cover loop wrap: with LEN=7 and loop=1, the step read back SHALL go 7 then 0; a STOP during HOLD SHALL give IDLE on the next cycle with done=0.
REQ-036 The bench SHALL cover STOP during a stalled ISSUE: m_valid SHALL remain high until m_ready; after the handshake, the FSM SHALL go to IDLE with no HOLD.
REQ-037 The bench SHALL cover START+STOP in the same write (CTRL=5) from IDLE: the block SHALL stay IDLE; START while busy SHALL leave step unchanged.
REQ-038 The bench SHALL cover reset asserted mid-ISSUE: m_valid SHALL be 0 within the same cycle, CTRL SHALL read 0, and STEP0 SHALL read 0.
